// File: rtl/mem_arb_pkg.sv
// Shared encodings for the single-port memory arbiter: FSM states, owner codes
// and the default memory read latency.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_IF  = 2'd0,
        OWN_D   = 2'd1,
        OWN_DBG = 2'd2
    } owner_t;

    localparam int DEFAULT_READ_LAT = 2;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker between fetch and data requests; a lone requester
// always wins, a tie goes to whichever side was not granted last.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic   req_if,
    input  logic   req_d,
    input  logic   last_d,
    output owner_t winner
);

    logic pick_d;

    assign pick_d = req_d && (!req_if || !last_d);
    assign winner = pick_d ? OWN_D : OWN_IF;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the single-port instruction/data memory with req/ack
// handshakes. Optional debug loader port enabled by MEM_ARB_DBG_PORT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = DEFAULT_READ_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
`ifdef MEM_ARB_DBG_PORT_EN
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
`endif
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    localparam logic [2:0] WAIT_INIT = 3'(READ_LAT - 1);

    arb_state_t        state;
    owner_t            owner;
    owner_t            rr_win;
    owner_t            win;
    logic [2:0]        cnt;
    logic              last_d;
    logic              we_q;
    logic              any_req;
    logic              resp_ack;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic [DATA_W-1:0] sel_wdata;

    rr_pick2 u_pick (
        .req_if (if_req),
        .req_d  (d_req),
        .last_d (last_d),
        .winner (rr_win)
    );

`ifdef MEM_ARB_DBG_PORT_EN
    assign any_req  = if_req | d_req | dbg_req;
    assign resp_ack = if_ack | d_ack | dbg_ack;
`else
    assign any_req  = if_req | d_req;
    assign resp_ack = if_ack | d_ack;
`endif

    // Debug pre-empts the round-robin pair without disturbing its history.
    always_comb begin
        win = rr_win;
`ifdef MEM_ARB_DBG_PORT_EN
        if (dbg_req) win = OWN_DBG;
`endif
    end

    always_comb begin
        sel_addr  = if_addr;
        sel_we    = 1'b0;
        sel_wdata = '0;
        case (win)
            OWN_D: begin
                sel_addr  = d_addr;
                sel_we    = d_we;
                sel_wdata = d_wdata;
            end
`ifdef MEM_ARB_DBG_PORT_EN
            OWN_DBG: begin
                sel_addr  = dbg_addr;
                sel_we    = dbg_we;
                sel_wdata = dbg_wdata;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d <= 1'b0;
        end else if (state == S_IDLE && (if_req || d_req) && win != OWN_DBG) begin
            last_d <= (win == OWN_D);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            owner    <= OWN_IF;
            cnt      <= '0;
            we_q     <= 1'b0;
            busy     <= 1'b0;
            mem_en   <= 1'b0;
            mem_ren  <= 1'b0;
            mem_wen  <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
`ifdef MEM_ARB_DBG_PORT_EN
            dbg_ack  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        state    <= S_ACCESS;
                        owner    <= win;
                        we_q     <= sel_we;
                        busy     <= 1'b1;
                        mem_en   <= 1'b1;
                        mem_ren  <= !sel_we;
                        mem_wen  <= sel_we;
                        mem_addr <= sel_addr;
                        mem_din  <= sel_wdata;
                    end
                end
                S_ACCESS: begin
                    mem_en   <= 1'b0;
                    mem_ren  <= 1'b0;
                    mem_wen  <= 1'b0;
                    mem_addr <= '0;
                    mem_din  <= '0;
                    // Stores complete at once; loads wait out the read latency.
                    if (we_q || READ_LAT == 1) begin
                        state   <= S_RESP;
                        if_ack  <= (owner == OWN_IF);
                        d_ack   <= (owner == OWN_D);
`ifdef MEM_ARB_DBG_PORT_EN
                        dbg_ack <= (owner == OWN_DBG);
`endif
                    end else begin
                        state <= S_WAIT;
                        cnt   <= WAIT_INIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state   <= S_RESP;
                        if_ack  <= (owner == OWN_IF);
                        d_ack   <= (owner == OWN_D);
`ifdef MEM_ARB_DBG_PORT_EN
                        dbg_ack <= (owner == OWN_DBG);
`endif
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    if_ack  <= 1'b0;
                    d_ack   <= 1'b0;
`ifdef MEM_ARB_DBG_PORT_EN
                    dbg_ack <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign rdata = (resp_ack && !we_q) ? mem_dout : '0;

endmodule
